// File: rtl/approx_mul8_seq.sv
// Multi-cycle approximate 8x8 unsigned multiplier: four nibble partial products
// are sequenced through one shared LM_NC_1_EC 4x4 core and shift-accumulated.

module LM_NC_1_EC (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] p
);
    // Mitchell log product (drops the residual product rx*ry) plus one correction
    // term that replaces the residual by its power-of-two upper bound.
    function automatic logic [1:0] lead_one(input logic [3:0] v);
        casez (v)
            4'b1???: lead_one = 2'd3;
            4'b01??: lead_one = 2'd2;
            4'b001?: lead_one = 2'd1;
            default: lead_one = 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] ceil_log2(input logic [2:0] q);
        case (q)
            3'd0, 3'd1: ceil_log2 = 2'd0;
            3'd2:       ceil_log2 = 2'd1;
            3'd3, 3'd4: ceil_log2 = 2'd2;
            default:    ceil_log2 = 2'd3;
        endcase
    endfunction

    logic [1:0] kx, ky, cx, cy;
    logic [3:0] rx4, ry4;
    logic [2:0] rx, ry;

    always_comb begin
        kx  = lead_one(x);
        ky  = lead_one(y);
        rx4 = x - (4'd1 << kx);
        ry4 = y - (4'd1 << ky);
        rx  = rx4[2:0];
        ry  = ry4[2:0];
        cx  = ceil_log2(rx);
        cy  = ceil_log2(ry);
        p   = 8'd0;
        if (x != 4'd0 && y != 4'd0) begin
            // bounded by 64 + 56 + 56 + 64 = 240, so 8 bits never overflow
            p = (8'd1 << ({1'b0, kx} + {1'b0, ky})) + ({5'd0, rx} << ky) + ({5'd0, ry} << kx);
            if (rx != 3'd0 && ry != 3'd0)
                p = p + (8'd1 << ({1'b0, cx} + {1'b0, cy}));
        end
    end
endmodule

module approx_mul8_seq #(
    parameter bit SKIP_LL = 1'b0,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      result,
    output logic             ovf,
    output logic [CNT_W-1:0] op_cnt
);
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t      state, state_nxt;
    logic [7:0]  a_q, b_q;
    logic [16:0] acc, addend;
    logic [2:0]  idx;
    logic [3:0]  core_x, core_y;
    logic [7:0]  pp;

    LM_NC_1_EC core (.x(core_x), .y(core_y), .p(pp));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // idx 0..3 accumulate partial products; idx 4 registers the saturated result
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = CALC;
            CALC:    if (abort) state_nxt = IDLE;
                     else if (idx == 3'd4) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_comb begin
        core_x = a_q[3:0];
        core_y = b_q[3:0];
        addend = 17'd0;
        case (idx)
            3'd0: addend = SKIP_LL ? 17'd0 : {9'd0, pp};
            3'd1: begin core_y = b_q[7:4]; addend = {5'd0, pp, 4'd0}; end
            3'd2: begin core_x = a_q[7:4]; addend = {5'd0, pp, 4'd0}; end
            3'd3: begin core_x = a_q[7:4]; core_y = b_q[7:4]; addend = {1'b0, pp, 8'd0}; end
            default: addend = 17'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= 8'd0;
            b_q    <= 8'd0;
            acc    <= 17'd0;
            idx    <= 3'd0;
            result <= 16'd0;
            ovf    <= 1'b0;
            op_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q <= a;
                    b_q <= b;
                    acc <= 17'd0;
                    idx <= 3'd0;
                end
                CALC: if (!abort) begin
                    if (idx == 3'd4) begin
                        result <= acc[16] ? 16'hFFFF : acc[15:0];
                        ovf    <= acc[16];
                    end else begin
                        acc <= acc + addend;
                        idx <= idx + 3'd1;
                    end
                end
                DONE: if (out_ready) op_cnt <= op_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                default: ;
            endcase
        end
    end
endmodule
